// File: rtl/bp_common_pkg.sv
// ============================================================================
//  Module   : bp_common_pkg
//  Purpose  : Shared host address map and host FSM state type.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package bp_common_pkg;

    localparam logic [63:0] host_getchar_addr_gp     = 64'h0000_0000_0010_0000;
    localparam logic [63:0] host_putchar_addr_gp     = 64'h0000_0000_0010_1000;
    localparam logic [63:0] host_finish_base_addr_gp = 64'h0000_0000_0010_2000;

    typedef enum logic [0:0] {
        e_ready = 1'b0,
        e_resp  = 1'b1
    } bp_nonsynth_host_state_e;

endpackage

`default_nettype wire

// File: rtl/bp_nonsynth_host_watchdog.sv
// ============================================================================
//  Module   : bp_nonsynth_host_watchdog
//  Purpose  : Saturating cycle counter with synchronous clear and enable.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bp_nonsynth_host_watchdog #(
    parameter int TIMEOUT_CYCLES_P = 1000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES_P + 1);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES_P);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk_i) begin
        if (reset_i || clear_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != LIMIT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign expired_o = (cnt_q == LIMIT);

endmodule

`default_nettype wire

// File: rtl/bp_nonsynth_host.sv
// ============================================================================
//  Module   : bp_nonsynth_host
//  Purpose  : Simulation host endpoint: putchar/getchar/finish decode, one
//             response per command. Optional watchdog: BP_HOST_WATCHDOG_EN.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bp_nonsynth_host
    import bp_common_pkg::*;
#(
    parameter int num_core_p       = 1,
    parameter int paddr_width_p    = 40,
    parameter int data_width_p     = 64,
    parameter int timeout_cycles_p = 1000000
) (
    input  logic                     clk_i,
    input  logic                     reset_i,

    input  logic                     io_cmd_v_i,
    output logic                     io_cmd_ready_o,
    input  logic [paddr_width_p-1:0] io_cmd_addr_i,
    input  logic                     io_cmd_we_i,
    input  logic [data_width_p-1:0]  io_cmd_data_i,

    output logic                     io_resp_v_o,
    input  logic                     io_resp_yumi_i,
    output logic [paddr_width_p-1:0] io_resp_addr_o,
    output logic                     io_resp_we_o,
    output logic [data_width_p-1:0]  io_resp_data_o,

    output logic                     char_v_o,
    output logic [7:0]               char_o,
    output logic [num_core_p-1:0]    finish_o,
    output logic                     all_finished_o,
    output logic                     fail_o,
    output logic                     err_o,
    output logic                     timeout_o
);

    localparam logic [8:0] NUM_CORE_SLOTS = 9'(num_core_p);

    bp_nonsynth_host_state_e state_q;

    logic                     resp_v_q;
    logic [paddr_width_p-1:0] resp_addr_q;
    logic                     resp_we_q;
    logic [data_width_p-1:0]  resp_data_q, resp_data_d;
    logic                     char_v_q, char_v_d;
    logic [7:0]               char_q, char_d;
    logic [num_core_p-1:0]    finish_q, finish_d;
    logic                     fail_q, fail_d;
    logic                     err_q, err_d;

    logic                     accept;
    logic                     is_getchar, is_putchar, is_finish;
    logic [8:0]               finish_slot;
    logic                     unused_data;

    assign accept = io_cmd_v_i && (state_q == e_ready);

    assign is_getchar  = (io_cmd_addr_i == host_getchar_addr_gp[paddr_width_p-1:0]);
    assign is_putchar  = (io_cmd_addr_i == host_putchar_addr_gp[paddr_width_p-1:0]);
    // Finish window is one 4 KiB page of 8-byte slots; slot index is the core id.
    assign is_finish   = (io_cmd_addr_i[paddr_width_p-1:12]
                          == host_finish_base_addr_gp[paddr_width_p-1:12])
                         && (io_cmd_addr_i[2:0] == 3'b000);
    assign finish_slot = io_cmd_addr_i[11:3];
    assign unused_data = ^io_cmd_data_i;

    always_comb begin
        resp_data_d = '0;
        char_v_d    = 1'b0;
        char_d      = char_q;
        finish_d    = finish_q;
        fail_d      = fail_q;
        err_d       = err_q;
        if (accept) begin
            if (is_getchar && !io_cmd_we_i) begin
                resp_data_d = '1;
            end else if (is_putchar && io_cmd_we_i) begin
                char_v_d = 1'b1;
                char_d   = io_cmd_data_i[7:0];
            end else if (is_finish && io_cmd_we_i) begin
                if (finish_slot >= NUM_CORE_SLOTS) begin
                    err_d = 1'b1;
                end else begin
                    for (int i = 0; i < num_core_p; i++) begin
                        if (finish_slot == 9'(i)) begin
                            finish_d[i] = 1'b1;
                        end
                    end
                    if (io_cmd_data_i[7:0] != 8'h00) begin
                        fail_d = 1'b1;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= e_ready;
            resp_v_q    <= 1'b0;
            resp_addr_q <= '0;
            resp_we_q   <= 1'b0;
            resp_data_q <= '0;
            char_v_q    <= 1'b0;
            char_q      <= 8'h00;
            finish_q    <= '0;
            fail_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            char_v_q <= char_v_d;
            char_q   <= char_d;
            finish_q <= finish_d;
            fail_q   <= fail_d;
            err_q    <= err_d;
            case (state_q)
                e_ready: begin
                    if (io_cmd_v_i) begin
                        state_q     <= e_resp;
                        resp_v_q    <= 1'b1;
                        resp_addr_q <= io_cmd_addr_i;
                        resp_we_q   <= io_cmd_we_i;
                        resp_data_q <= resp_data_d;
                    end
                end
                e_resp: begin
                    if (io_resp_yumi_i) begin
                        state_q  <= e_ready;
                        resp_v_q <= 1'b0;
                    end
                end
                default: begin
                    state_q  <= e_ready;
                    resp_v_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef BP_HOST_WATCHDOG_EN
    logic timeout_q;
    logic wd_expired;

    bp_nonsynth_host_watchdog #(
        .TIMEOUT_CYCLES_P (timeout_cycles_p)
    ) u_watchdog (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (accept),
        .en_i      (~all_finished_o),
        .expired_o (wd_expired)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            timeout_q <= 1'b0;
        end else if (wd_expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout_o = timeout_q;
`else
    assign timeout_o = 1'b0;
`endif

    assign io_cmd_ready_o = (state_q == e_ready);
    assign io_resp_v_o    = resp_v_q;
    assign io_resp_addr_o = resp_addr_q;
    assign io_resp_we_o   = resp_we_q;
    assign io_resp_data_o = resp_data_q;
    assign char_v_o       = char_v_q;
    assign char_o         = char_q;
    assign finish_o       = finish_q;
    assign all_finished_o = &finish_q;
    assign fail_o         = fail_q;
    assign err_o          = err_q;

`ifndef SYNTHESIS
    a_yumi_needs_resp: assert property (@(posedge clk_i) disable iff (reset_i)
        io_resp_yumi_i |-> io_resp_v_o);
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_nonsynth_host.sv
// ============================================================================
//  Module   : tb_bp_nonsynth_host
//  Purpose  : Directed self-checking bench for bp_nonsynth_host (2 cores).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_bp_nonsynth_host;

    localparam int NUM_CORE = 2;
    localparam int PADDR_W  = 40;
    localparam int DATA_W   = 64;
    localparam int TIMEOUT  = 16;

    logic               clk = 1'b0;
    logic               reset;
    logic               cmd_v;
    logic               cmd_ready;
    logic [PADDR_W-1:0] cmd_addr;
    logic               cmd_we;
    logic [DATA_W-1:0]  cmd_data;
    logic               resp_v;
    logic               resp_yumi;
    logic [PADDR_W-1:0] resp_addr;
    logic               resp_we;
    logic [DATA_W-1:0]  resp_data;
    logic               char_v;
    logic [7:0]         char_b;
    logic [NUM_CORE-1:0] finish;
    logic               all_finished;
    logic               fail;
    logic               err;
    logic               timeout;

    int tests_run = 0;
    int tests_failed = 0;

    bp_nonsynth_host #(
        .num_core_p       (NUM_CORE),
        .paddr_width_p    (PADDR_W),
        .data_width_p     (DATA_W),
        .timeout_cycles_p (TIMEOUT)
    ) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .io_cmd_v_i     (cmd_v),
        .io_cmd_ready_o (cmd_ready),
        .io_cmd_addr_i  (cmd_addr),
        .io_cmd_we_i    (cmd_we),
        .io_cmd_data_i  (cmd_data),
        .io_resp_v_o    (resp_v),
        .io_resp_yumi_i (resp_yumi),
        .io_resp_addr_o (resp_addr),
        .io_resp_we_o   (resp_we),
        .io_resp_data_o (resp_data),
        .char_v_o       (char_v),
        .char_o         (char_b),
        .finish_o       (finish),
        .all_finished_o (all_finished),
        .fail_o         (fail),
        .err_o          (err),
        .timeout_o      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cmd_v = 1'b0;
        resp_yumi = 1'b0;
        step();
        reset = 1'b0;
    endtask

    // Presents one command for a single edge; returns one cycle after accept.
    task automatic send(input logic [PADDR_W-1:0] a, input logic we, input logic [DATA_W-1:0] d);
        check("ready_before_send", cmd_ready, 1'b1);
        cmd_v    = 1'b1;
        cmd_addr = a;
        cmd_we   = we;
        cmd_data = d;
        step();
        cmd_v = 1'b0;
        check("resp_v_after_accept", resp_v, 1'b1);
        check("resp_addr_echo", resp_addr, 64'(a));
        check("resp_we_echo", resp_we, we);
    endtask

    task automatic consume();
        resp_yumi = 1'b1;
        step();
        resp_yumi = 1'b0;
        check("resp_v_after_yumi", resp_v, 1'b0);
        check("ready_after_yumi", cmd_ready, 1'b1);
    endtask

    initial begin
        cmd_addr = '0;
        cmd_we   = 1'b0;
        cmd_data = '0;
        do_reset();

        // Reset state
        check("rst_ready", cmd_ready, 1'b1);
        check("rst_resp_v", resp_v, 1'b0);
        check("rst_char_v", char_v, 1'b0);
        check("rst_finish", finish, 2'b00);
        check("rst_flags", {all_finished, fail, err, timeout}, 4'b0000);

        // Putchar
        send(40'h10_1000, 1'b1, 64'h41);
        check("put_char_v", char_v, 1'b1);
        check("put_char", char_b, 8'h41);
        check("put_ready_low", cmd_ready, 1'b0);
        check("put_resp_data", resp_data, 64'h0);
        step();
        check("put_char_v_one_cycle", char_v, 1'b0);
        check("put_resp_held", resp_v, 1'b1);
        consume();

        // Finish pass on both cores
        send(40'h10_2000, 1'b1, 64'h0);
        check("fin0_finish", finish, 2'b01);
        check("fin0_all", all_finished, 1'b0);
        consume();
        send(40'h10_2008, 1'b1, 64'h0);
        check("fin1_finish", finish, 2'b11);
        check("fin1_all", all_finished, 1'b1);
        check("fin1_fail", fail, 1'b0);
        check("fin1_err", err, 1'b0);
        consume();

        // Finish fail, repeated
        do_reset();
        check("rst2_finish", finish, 2'b00);
        for (int k = 0; k < 2; k++) begin
            send(40'h10_2000, 1'b1, 64'h3);
            check("ffail_finish", finish, 2'b01);
            check("ffail_fail", fail, 1'b1);
            check("ffail_all", all_finished, 1'b0);
            consume();
        end

        // Backpressure with a second command waiting
        send(40'h10_1000, 1'b1, 64'h142);
        cmd_v    = 1'b1;
        cmd_addr = 40'h10_0000;
        cmd_we   = 1'b0;
        cmd_data = 64'h0;
        for (int k = 0; k < 5; k++) begin
            step();
            check("bp_resp_v", resp_v, 1'b1);
            check("bp_resp_addr", resp_addr, 64'h10_1000);
            check("bp_resp_we", resp_we, 1'b1);
            check("bp_ready", cmd_ready, 1'b0);
        end
        check("bp_char", char_b, 8'h42);
        resp_yumi = 1'b1;
        step();
        resp_yumi = 1'b0;
        check("bp_yumi_resp_v", resp_v, 1'b0);
        check("bp_yumi_ready", cmd_ready, 1'b1);
        step();
        cmd_v = 1'b0;
        check("bp_second_resp_v", resp_v, 1'b1);
        check("getchar_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        check("getchar_we", resp_we, 1'b0);
        check("getchar_err", err, 1'b0);
        consume();

        // Unmapped address
        send(40'h20_0000, 1'b1, 64'h55);
        check("unmapped_data", resp_data, 64'h0);
        check("unmapped_err", err, 1'b1);
        consume();

        // Bad core id
        do_reset();
        check("rst3_err", err, 1'b0);
        send(40'h10_2010, 1'b1, 64'h0);
        check("badcid_err", err, 1'b1);
        check("badcid_finish", finish, 2'b00);
        consume();

        // Reset while a response is pending
        send(40'h10_1000, 1'b1, 64'h43);
        check("rstmid_pre_v", resp_v, 1'b1);
        do_reset();
        check("rstmid_resp_v", resp_v, 1'b0);
        check("rstmid_char_v", char_v, 1'b0);
        check("rstmid_err", err, 1'b0);
        check("rstmid_ready", cmd_ready, 1'b1);

        // Idle watchdog
        repeat (10) step();
        check("wd_early", timeout, 1'b0);
        repeat (10) step();
`ifdef BP_HOST_WATCHDOG_EN
        check("wd_expired", timeout, 1'b1);
`else
        check("wd_tied_low", timeout, 1'b0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
